pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush sequencer for a 5-stage MIPS pipeline (IF/ID/EX/MEM/WB) with
// no forwarding and control transfers resolved in MEM.
//
// Event priority within a cycle, highest first:
//   1. MemBusy     freeze PC, IF/ID, ID/EX and EX/MEM, and bubble MEM/WB.
//   2. M_Redirect  squash IF/ID, ID/EX and EX/MEM and load the new PC.
//   3. RAW hazard  hold PC and IF/ID, and bubble ID/EX.
// The control outputs are combinational from the current inputs, so they act
// in the same cycle. They are forced low while Reset is high.
//
// The state register records which event was handled last. DbgState exposes it
// so it can be observed: 0 = RUN, 1 = RAW_STALL, 2 = MEM_WAIT.
//
// wait_cnt counts consecutive busy cycles and saturates at WAIT_TIMEOUT.
// Timeout is a sticky flag that only Reset clears.
//
// Optional feature macro: HAZARD_STATS_EN. When it is defined, the module
// gains the saturating counters StallCount and FlushCount.
module pipeline_hazard_ctrl #(
  parameter int WAIT_TIMEOUT = 64,
  parameter bit WB_BYPASS    = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRs,
  input  logic       ID_UsesRt,
  input  logic [4:0] EX_WriteReg,
  input  logic       EX_RegWrite,
  input  logic [4:0] MEM_WriteReg,
  input  logic       MEM_RegWrite,
  input  logic [4:0] WB_WriteReg,
  input  logic       WB_RegWrite,
  input  logic       M_Redirect,
  input  logic       MemBusy,
  output logic       PCWrite,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic       IDEX_Write,
  output logic       IDEX_Flush,
  output logic       EXMEM_Write,
  output logic       EXMEM_Flush,
  output logic       MEMWB_Flush,
  output logic       Stalled,
  output logic       Timeout,
  output logic [1:0] DbgState
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  localparam int CW = $clog2(WAIT_TIMEOUT) + 1;
  localparam logic [CW-1:0] WT = CW'(WAIT_TIMEOUT);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    RAW_STALL = 2'd1,
    MEM_WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;

  logic wb_we_eff, rs_hit, rt_hit, hazard;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic exmem_write, exmem_flush, memwb_flush, stalled;

  // An older writer matches a source register only if it writes a non-zero register.
  function automatic logic reg_hit(input logic we, input logic [4:0] wr, input logic [4:0] src);
    return we && (wr != 5'd0) && (wr == src);
  endfunction

  // With a write-before-read register file, a WB-stage writer is already visible to ID.
  assign wb_we_eff = WB_RegWrite & ~WB_BYPASS;

  // RAW detection between the ID sources and every in-flight writer that is still pending.
  always_comb begin
    rs_hit = reg_hit(EX_RegWrite, EX_WriteReg, ID_Rs) |
             reg_hit(MEM_RegWrite, MEM_WriteReg, ID_Rs) |
             reg_hit(wb_we_eff, WB_WriteReg, ID_Rs);
    rt_hit = reg_hit(EX_RegWrite, EX_WriteReg, ID_Rt) |
             reg_hit(MEM_RegWrite, MEM_WriteReg, ID_Rt) |
             reg_hit(wb_we_eff, WB_WriteReg, ID_Rt);
    hazard = (ID_UsesRs & rs_hit) | (ID_UsesRt & rt_hit);
  end

  // Prioritised event decode: the pipeline controls and the next state.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    stalled     = 1'b0;
    state_d     = RUN;
    if (MemBusy) begin
      // Redirects and hazards are masked here and get looked at again once memory is ready.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
      stalled     = 1'b1;
      state_d     = MEM_WAIT;
    end else if (M_Redirect) begin
      // The redirect squashes the hazarding instruction, so any RAW stall is dropped.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = RUN;
    end else if (hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
      stalled     = 1'b1;
      state_d     = RAW_STALL;
    end
  end

  // Busy-cycle counter and sticky timeout detection.
  always_comb begin
    wait_cnt_d = '0;
    timeout_d  = timeout_q;
    if (MemBusy) begin
      wait_cnt_d = (wait_cnt_q == WT) ? wait_cnt_q : wait_cnt_q + 1'b1;
      if (wait_cnt_d == WT) timeout_d = 1'b1;
    end
  end

  // State, wait counter and timeout flops, all cleared asynchronously.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Outputs are gated by Reset so the pipeline is fully held while reset is applied.
  assign PCWrite     = pc_write    & ~Reset;
  assign IFID_Write  = ifid_write  & ~Reset;
  assign IFID_Flush  = ifid_flush  & ~Reset;
  assign IDEX_Write  = idex_write  & ~Reset;
  assign IDEX_Flush  = idex_flush  & ~Reset;
  assign EXMEM_Write = exmem_write & ~Reset;
  assign EXMEM_Flush = exmem_flush & ~Reset;
  assign MEMWB_Flush = memwb_flush & ~Reset;
  assign Stalled     = stalled     & ~Reset;
  assign Timeout     = timeout_q;
  assign DbgState    = state_q;

`ifdef HAZARD_STATS_EN
  // Saturating event counters. A redirect counts only when it executes, not when a busy memory masks it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stalled && (StallCount != 32'hFFFF_FFFF)) StallCount <= StallCount + 32'd1;
      if (M_Redirect && !MemBusy && (FlushCount != 32'hFFFF_FFFF)) FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl.
// Two instances share the same stimulus:
//   dut_a  WAIT_TIMEOUT=4,  WB_BYPASS=0
//   dut_b  WAIT_TIMEOUT=64, WB_BYPASS=1
// Each observation vector is {controls[8:0], Timeout, DbgState}. The control
// bits, from bit 8 down to bit 0, are:
//   PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
//   EXMEM_Write, EXMEM_Flush, MEMWB_Flush, Stalled.
module tb_pipeline_hazard_ctrl;

  localparam int WT_A = 4;
  localparam int WT_B = 64;
  localparam int EV_NONE = 0, EV_BUSY = 1, EV_REDIR = 2, EV_HAZ = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_wr, mem_wr, wb_wr;
  logic       uses_rs, uses_rt, ex_we, mem_we, wb_we, redirect, busy;

  wire [8:0]  ctrl_a, ctrl_b;
  wire        tmo_a, tmo_b;
  wire [1:0]  st_a, st_b;
  wire [11:0] obs_a = {ctrl_a, tmo_a, st_a};
  wire [11:0] obs_b = {ctrl_b, tmo_b, st_b};
`ifdef HAZARD_STATS_EN
  wire [31:0] sc_a, fc_a, sc_b, fc_b;
`endif

  pipeline_hazard_ctrl #(.WAIT_TIMEOUT(WT_A), .WB_BYPASS(1'b0)) dut_a (
    .Clk(clk), .Reset(rst), .ID_Rs(id_rs), .ID_Rt(id_rt),
    .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt),
    .EX_WriteReg(ex_wr), .EX_RegWrite(ex_we),
    .MEM_WriteReg(mem_wr), .MEM_RegWrite(mem_we),
    .WB_WriteReg(wb_wr), .WB_RegWrite(wb_we),
    .M_Redirect(redirect), .MemBusy(busy),
    .PCWrite(ctrl_a[8]), .IFID_Write(ctrl_a[7]), .IFID_Flush(ctrl_a[6]),
    .IDEX_Write(ctrl_a[5]), .IDEX_Flush(ctrl_a[4]),
    .EXMEM_Write(ctrl_a[3]), .EXMEM_Flush(ctrl_a[2]),
    .MEMWB_Flush(ctrl_a[1]), .Stalled(ctrl_a[0]),
    .Timeout(tmo_a), .DbgState(st_a)
`ifdef HAZARD_STATS_EN
    , .StallCount(sc_a), .FlushCount(fc_a)
`endif
  );

  pipeline_hazard_ctrl #(.WAIT_TIMEOUT(WT_B), .WB_BYPASS(1'b1)) dut_b (
    .Clk(clk), .Reset(rst), .ID_Rs(id_rs), .ID_Rt(id_rt),
    .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt),
    .EX_WriteReg(ex_wr), .EX_RegWrite(ex_we),
    .MEM_WriteReg(mem_wr), .MEM_RegWrite(mem_we),
    .WB_WriteReg(wb_wr), .WB_RegWrite(wb_we),
    .M_Redirect(redirect), .MemBusy(busy),
    .PCWrite(ctrl_b[8]), .IFID_Write(ctrl_b[7]), .IFID_Flush(ctrl_b[6]),
    .IDEX_Write(ctrl_b[5]), .IDEX_Flush(ctrl_b[4]),
    .EXMEM_Write(ctrl_b[3]), .EXMEM_Flush(ctrl_b[2]),
    .MEMWB_Flush(ctrl_b[1]), .Stalled(ctrl_b[0]),
    .Timeout(tmo_b), .DbgState(st_b)
`ifdef HAZARD_STATS_EN
    , .StallCount(sc_b), .FlushCount(fc_b)
`endif
  );

  // ---------------- reference model ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  int         busy_run_m[2];
  logic       tmo_m[2];
  logic [1:0] st_m[2];
  int         stall_m[2];
  int         flush_m[2];

  // Gather the pending writers, then test whether any used source is among them.
  function automatic logic model_hazard(input bit bypass);
    logic [4:0] writers[$];
    if (ex_we)              writers.push_back(ex_wr);
    if (mem_we)             writers.push_back(mem_wr);
    if (wb_we && !bypass)   writers.push_back(wb_wr);
    foreach (writers[k]) begin
      if (writers[k] != 5'd0) begin
        if (uses_rs && writers[k] == id_rs) return 1'b1;
        if (uses_rt && writers[k] == id_rt) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int model_event(input bit bypass);
    if (busy)                 return EV_BUSY;
    if (redirect)             return EV_REDIR;
    if (model_hazard(bypass)) return EV_HAZ;
    return EV_NONE;
  endfunction

  function automatic logic [8:0] exp_ctrl(input bit bypass);
    if (rst) return 9'b0;
    case (model_event(bypass))
      EV_BUSY:  return 9'b0_0_0_0_0_0_0_1_1;
      EV_REDIR: return 9'b1_1_1_1_1_1_1_0_0;
      EV_HAZ:   return 9'b0_0_0_1_1_1_0_0_1;
      default:  return 9'b1_1_0_1_0_1_0_0_0;
    endcase
  endfunction

  function automatic logic [1:0] exp_state_of(input int ev);
    case (ev)
      EV_BUSY: return 2'd2;
      EV_HAZ:  return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [11:0] exp_obs(input int i);
    return {exp_ctrl(i == 1), tmo_m[i], st_m[i]};
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      busy_run_m[i] = 0; tmo_m[i] = 1'b0; st_m[i] = 2'd0;
      stall_m[i] = 0; flush_m[i] = 0;
    end
  endtask

  // Advance one clock. The model consumes the inputs that are present at the edge.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      int ev;
      int wt;
      ev = model_event(i == 1);
      wt = (i == 0) ? WT_A : WT_B;
      if (rst) begin
        busy_run_m[i] = 0; tmo_m[i] = 1'b0; st_m[i] = 2'd0;
        stall_m[i] = 0; flush_m[i] = 0;
      end else begin
        if (ev == EV_BUSY) begin
          if (busy_run_m[i] < wt) busy_run_m[i]++;
          if (busy_run_m[i] >= wt) tmo_m[i] = 1'b1;
        end else begin
          busy_run_m[i] = 0;
        end
        st_m[i] = exp_state_of(ev);
        if (ev == EV_BUSY || ev == EV_HAZ) stall_m[i]++;
        if (ev == EV_REDIR) flush_m[i]++;
      end
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; uses_rs = 1'b0; uses_rt = 1'b0;
    ex_wr = 5'd0; ex_we = 1'b0; mem_wr = 5'd0; mem_we = 1'b0;
    wb_wr = 5'd0; wb_we = 1'b0; redirect = 1'b0; busy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    reset_model();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; busy = 1'b1; redirect = 1'b1;
    ex_we = 1'b1; ex_wr = 5'd3; id_rs = 5'd3; uses_rs = 1'b1;
    reset_model();
    @(negedge clk);
    n_checks++;
    if (obs_a !== 12'h000) $display("FAIL reset_a got=%h exp=%h", obs_a, 12'h000); else n_pass++;
    n_checks++;
    if (obs_b !== 12'h000) $display("FAIL reset_b got=%h exp=%h", obs_b, 12'h000); else n_pass++;
    tick();
    set_idle();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctrl_a !== 9'b1_1_0_1_0_1_0_0_0) $display("FAIL idle_default got=%b exp=%b", ctrl_a, 9'b110101000); else n_pass++;
    n_checks++;
    if (obs_b !== exp_obs(1)) $display("FAIL idle_default_b got=%h exp=%h", obs_b, exp_obs(1)); else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    int stalls_a, stalls_b;
    stalls_a = 0; stalls_b = 0;
    set_idle();
    id_rs = 5'd8; uses_rs = 1'b1; ex_wr = 5'd8; mem_wr = 5'd8; wb_wr = 5'd8;
    for (int c = 0; c < 4; c++) begin
      ex_we = (c == 0); mem_we = (c == 1); wb_we = (c == 2);
      @(negedge clk);
      n_checks++;
      if (obs_a !== exp_obs(0)) $display("FAIL load_use_a cyc=%0d got=%h exp=%h", c, obs_a, exp_obs(0)); else n_pass++;
      n_checks++;
      if (obs_b !== exp_obs(1)) $display("FAIL load_use_b cyc=%0d got=%h exp=%h", c, obs_b, exp_obs(1)); else n_pass++;
      if (!ctrl_a[8]) stalls_a++;
      if (!ctrl_b[8]) stalls_b++;
      tick();
    end
    n_checks++;
    if (stalls_a !== 3) $display("FAIL load_use_len_a got=%0d exp=3", stalls_a); else n_pass++;
    n_checks++;
    if (stalls_b !== 2) $display("FAIL load_use_len_bypass got=%0d exp=2", stalls_b); else n_pass++;
    set_idle();
  endtask

  task automatic test_reg0();
    set_idle();
    id_rs = 5'd0; uses_rs = 1'b1; ex_wr = 5'd0; ex_we = 1'b1; mem_wr = 5'd0; mem_we = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctrl_a[0] !== 1'b0) $display("FAIL reg0_stalled got=%b exp=0", ctrl_a[0]); else n_pass++;
    n_checks++;
    if (obs_a !== exp_obs(0)) $display("FAIL reg0_a got=%h exp=%h", obs_a, exp_obs(0)); else n_pass++;
    tick();
    set_idle();
  endtask

  task automatic test_redirect_in_stall();
    set_idle();
    id_rt = 5'd5; uses_rt = 1'b1; ex_wr = 5'd5; ex_we = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs_a !== exp_obs(0)) $display("FAIL redir_stall_c1 got=%h exp=%h", obs_a, exp_obs(0)); else n_pass++;
    tick();
    ex_we = 1'b0; mem_wr = 5'd5; mem_we = 1'b1; redirect = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ctrl_a[6], ctrl_a[4], ctrl_a[2], ctrl_a[8]} !== 4'b1111)
      $display("FAIL redir_stall_flush got=%b exp=1111", {ctrl_a[6], ctrl_a[4], ctrl_a[2], ctrl_a[8]});
    else n_pass++;
    n_checks++;
    if (obs_b !== exp_obs(1)) $display("FAIL redir_stall_c2_b got=%h exp=%h", obs_b, exp_obs(1)); else n_pass++;
    tick();
    set_idle();
    @(negedge clk);
    n_checks++;
    if ({st_a, ctrl_a[0]} !== 3'b000) $display("FAIL redir_stall_c3 got=%b exp=000", {st_a, ctrl_a[0]}); else n_pass++;
    tick();
  endtask

  task automatic test_busy_redirect();
    set_idle();
    busy = 1'b1; redirect = 1'b1;
    id_rs = 5'd7; uses_rs = 1'b1; ex_wr = 5'd7; ex_we = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (ctrl_a !== 9'b0_0_0_0_0_0_0_1_1) $display("FAIL busy_redir_c%0d got=%b exp=000000011", c, ctrl_a); else n_pass++;
      n_checks++;
      if (obs_b !== exp_obs(1)) $display("FAIL busy_redir_b_c%0d got=%h exp=%h", c, obs_b, exp_obs(1)); else n_pass++;
      tick();
    end
    busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctrl_a !== 9'b1_1_1_1_1_1_1_0_0) $display("FAIL busy_redir_exec got=%b exp=111111100", ctrl_a); else n_pass++;
    n_checks++;
    if (obs_a !== exp_obs(0)) $display("FAIL busy_redir_exec_obs got=%h exp=%h", obs_a, exp_obs(0)); else n_pass++;
    tick();
    set_idle();
    do_reset();
  endtask

  task automatic test_timeout();
    set_idle();
    do_reset();
    busy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (tmo_a !== (c >= 4)) $display("FAIL timeout_rise c=%0d got=%b exp=%b", c, tmo_a, (c >= 4)); else n_pass++;
      n_checks++;
      if (obs_a !== exp_obs(0)) $display("FAIL timeout_obs c=%0d got=%h exp=%h", c, obs_a, exp_obs(0)); else n_pass++;
      tick();
    end
    busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (tmo_a !== 1'b1) $display("FAIL timeout_sticky c=%0d got=%b exp=1", c, tmo_a); else n_pass++;
      tick();
    end
    n_checks++;
    if (tmo_b !== 1'b0) $display("FAIL timeout_long_b got=%b exp=0", tmo_b); else n_pass++;
    rst = 1'b1;
    reset_model();
    #1;
    n_checks++;
    if (tmo_a !== 1'b0) $display("FAIL timeout_reset got=%b exp=0", tmo_a); else n_pass++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 79) == 0);
      busy     = ($urandom_range(0, 5) == 0);
      redirect = ($urandom_range(0, 6) == 0);
      id_rs    = 5'($urandom_range(0, 3));
      id_rt    = 5'($urandom_range(0, 3));
      uses_rs  = 1'($urandom_range(0, 1));
      uses_rt  = 1'($urandom_range(0, 1));
      ex_wr    = 5'($urandom_range(0, 3));
      mem_wr   = 5'($urandom_range(0, 3));
      wb_wr    = 5'($urandom_range(0, 3));
      ex_we    = 1'($urandom_range(0, 1));
      mem_we   = 1'($urandom_range(0, 1));
      wb_we    = 1'($urandom_range(0, 1));
      if (rst) reset_model();
      @(negedge clk);
      n_checks++;
      if (obs_a !== exp_obs(0)) $display("FAIL random_a n=%0d got=%h exp=%h", n, obs_a, exp_obs(0)); else n_pass++;
      n_checks++;
      if (obs_b !== exp_obs(1)) $display("FAIL random_b n=%0d got=%h exp=%h", n, obs_b, exp_obs(1)); else n_pass++;
`ifdef HAZARD_STATS_EN
      n_checks++;
      if ({sc_a, fc_a} !== {32'(stall_m[0]), 32'(flush_m[0])})
        $display("FAIL random_stats_a n=%0d got=%0d/%0d exp=%0d/%0d", n, sc_a, fc_a, stall_m[0], flush_m[0]);
      else n_pass++;
`endif
      tick();
    end
    set_idle();
    do_reset();
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    set_idle();
    do_reset();
    id_rs = 5'd9; uses_rs = 1'b1; ex_wr = 5'd9; ex_we = 1'b1;
    repeat (3) tick();
    set_idle();
    redirect = 1'b1;
    repeat (2) tick();
    set_idle();
    tick();
    @(negedge clk);
    n_checks++;
    if (sc_a !== 32'd3) $display("FAIL stats_stall got=%0d exp=3", sc_a); else n_pass++;
    n_checks++;
    if (fc_a !== 32'd2) $display("FAIL stats_flush got=%0d exp=2", fc_a); else n_pass++;
    @(posedge clk);
    #3;
    rst = 1'b1;
    reset_model();
    #1;
    n_checks++;
    if ({sc_a, fc_a, sc_b, fc_b} !== 128'd0) $display("FAIL stats_async_reset got=%0d/%0d exp=0/0", sc_a, fc_a); else n_pass++;
    tick();
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    set_idle();
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_reg0();
    test_redirect_in_stall();
    test_busy_redirect();
    test_timeout();
    test_random();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
